// File: rtl/immgen_pipe_pkg.sv
// Shared types and helpers for the immediate generator pipeline (package briski_imm_pkg).
// Optional CSR-uimm/shamt immediates are enabled by defining IMMGEN_ZIMM_EN.
package briski_imm_pkg;

    typedef enum logic [2:0] {
        IMM_U,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_HARTID,
        IMM_ZIMM,
        IMM_SHAMT
    } imm_sel_e;

    localparam int MIN_PIPE_STAGES = 1;
    localparam int MAX_PIPE_STAGES = 3;
    localparam int MAX_XLEN        = 64;

    // Sign-extends the low 'width' bits of val to MAX_XLEN; callers truncate to their XLEN.
    function automatic logic [MAX_XLEN-1:0] sext_to_xlen(input logic [31:0] val,
                                                         input logic [6:0]  width);
        logic [MAX_XLEN-1:0] w_tmp;
        w_tmp = {32'b0, val} << (7'd64 - width);
        return MAX_XLEN'($signed(w_tmp) >>> (7'd64 - width));
    endfunction

endpackage

// File: rtl/immgen_pipe_if.sv
// Decode-side bundle for immgen_pipe. i_valid qualifies the instruction inputs for one cycle;
// there is no ready: the producer holds or drops its word while i_stall is high, o_valid qualifies outputs.
interface immgen_pipe_if #(
    parameter int XLEN = 32,
    parameter int TW   = 4
);
    logic            i_valid;
    logic [24:0]     i_instruction;
    logic [2:0]      i_imm_sel;
    logic [TW-1:0]   i_thread_index;
    logic            i_stall;
    logic            i_flush;
    logic            o_valid;
    logic [XLEN-1:0] o_imm_out;
    logic [TW-1:0]   o_thread_index;

    modport master (
        output i_valid, i_instruction, i_imm_sel, i_thread_index, i_stall, i_flush,
        input  o_valid, o_imm_out, o_thread_index
    );

    modport slave (
        input  i_valid, i_instruction, i_imm_sel, i_thread_index, i_stall, i_flush,
        output o_valid, o_imm_out, o_thread_index
    );
endinterface

// File: rtl/immgen_pipe_stage.sv
// One pipeline register stage: valid, immediate data and thread index.
// Flush clears valid only; stall freezes everything; flush wins over stall for valid.
module immgen_stage #(
    parameter int XLEN = 32,
    parameter int TW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_data,
    input  logic [TW-1:0]   i_thread,
    output logic            o_valid,
    output logic [XLEN-1:0] o_data,
    output logic [TW-1:0]   o_thread
);
    logic            r_valid;
    logic [XLEN-1:0] r_data;
    logic [TW-1:0]   r_thread;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_thread <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (!i_stall) begin
                r_valid <= i_valid;
            end
            // Data loads regardless of valid; consumers qualify with valid.
            if (!i_stall) begin
                r_data   <= i_data;
                r_thread <= i_thread;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_thread = r_thread;
endmodule

// File: rtl/immgen_pipe.sv
// Immediate generator for the barrel-threaded decode stage: decode/select then PIPE_STAGES registers.
// Define IMMGEN_ZIMM_EN to enable CSR uimm (sel 110) and shamt (sel 111) immediates.
module immgen_pipe
    import briski_imm_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              NUM_THREADS  = 16,
    parameter logic [XLEN-1:0] HART_ID_BASE = '0,
    parameter int              PIPE_STAGES  = 1
) (
    input  logic clk,
    input  logic reset,
    immgen_pipe_if.slave bus
);
    localparam int TW  = $clog2(NUM_THREADS);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immgen_pipe: XLEN must be 32 or 64");
    end
    if (PIPE_STAGES < MIN_PIPE_STAGES || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_pipe
        $error("immgen_pipe: PIPE_STAGES must be 1..3");
    end
    if (NUM_THREADS < 2 || (NUM_THREADS & (NUM_THREADS - 1)) != 0) begin : g_bad_threads
        $error("immgen_pipe: NUM_THREADS must be a power of two >= 2");
    end

    imm_sel_e        w_sel;
    logic [24:0]     w_inst;
    logic [XLEN-1:0] w_imm;

    assign w_sel  = imm_sel_e'(bus.i_imm_sel);
    assign w_inst = bus.i_instruction;

    // w_inst[n] holds instruction bit n+7.
    always_comb begin
        w_imm = '0;
        unique case (w_sel)
            IMM_U:      w_imm = XLEN'(sext_to_xlen({w_inst[24:5], 12'b0}, 7'd32));
            IMM_I:      w_imm = XLEN'(sext_to_xlen(32'(w_inst[24:13]), 7'd12));
            IMM_S:      w_imm = XLEN'(sext_to_xlen(32'({w_inst[24:18], w_inst[4:0]}), 7'd12));
            IMM_B:      w_imm = XLEN'(sext_to_xlen(32'({w_inst[24], w_inst[0], w_inst[23:18],
                                                       w_inst[4:1], 1'b0}), 7'd13));
            IMM_J:      w_imm = XLEN'(sext_to_xlen(32'({w_inst[24], w_inst[12:5], w_inst[13],
                                                       w_inst[23:14], 1'b0}), 7'd21));
            IMM_HARTID: w_imm = HART_ID_BASE + XLEN'(bus.i_thread_index);
`ifdef IMMGEN_ZIMM_EN
            IMM_ZIMM:   w_imm = XLEN'(w_inst[12:8]);
            IMM_SHAMT:  w_imm = XLEN'(w_inst[13+SHW-1:13]);
`endif
            default:    w_imm = '0;
        endcase
    end

    logic [PIPE_STAGES:0]           w_valid;
    logic [PIPE_STAGES:0][XLEN-1:0] w_data;
    logic [PIPE_STAGES:0][TW-1:0]   w_thread;

    assign w_valid[0]  = bus.i_valid;
    assign w_data[0]   = w_imm;
    assign w_thread[0] = bus.i_thread_index;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        immgen_stage #(
            .XLEN (XLEN),
            .TW   (TW)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .i_stall  (bus.i_stall),
            .i_flush  (bus.i_flush),
            .i_valid  (w_valid[g]),
            .i_data   (w_data[g]),
            .i_thread (w_thread[g]),
            .o_valid  (w_valid[g+1]),
            .o_data   (w_data[g+1]),
            .o_thread (w_thread[g+1])
        );
    end

    assign bus.o_valid        = w_valid[PIPE_STAGES];
    assign bus.o_imm_out      = w_data[PIPE_STAGES];
    assign bus.o_thread_index = w_thread[PIPE_STAGES];
endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: three configurations (32b/1 stage, 64b/2 stages, 32b/3 stages) share one
// stimulus stream; a scoreboard queue tracks each in-flight entry. Honours IMMGEN_ZIMM_EN.
module tb_immgen_pipe;
    import briski_imm_pkg::*;

    localparam int          TW     = 4;
    localparam logic [31:0] BASE_A = 32'hFFFF_FFFE;
    localparam logic [63:0] BASE_B = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] BASE_C = 32'h0000_0100;
`ifdef IMMGEN_ZIMM_EN
    localparam logic [63:0] ZIMM_EXP = 64'd17;
`else
    localparam logic [63:0] ZIMM_EXP = 64'd0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic [31:0]   inst  = '0;
    logic [2:0]    sel   = '0;
    logic [TW-1:0] thr   = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    int            tests = 0;
    int            fails = 0;

    typedef struct {
        int            k;
        logic [63:0]   d;
        logic [TW-1:0] t;
        int            pos;
    } ent_t;
    ent_t exp_q[$];

    always #5 clk = ~clk;

    immgen_pipe_if #(.XLEN(32), .TW(TW)) if_a ();
    immgen_pipe_if #(.XLEN(64), .TW(TW)) if_b ();
    immgen_pipe_if #(.XLEN(32), .TW(TW)) if_c ();

    assign if_a.i_valid = valid;  assign if_a.i_instruction = inst[31:7];  assign if_a.i_imm_sel = sel;
    assign if_a.i_thread_index = thr;  assign if_a.i_stall = stall;  assign if_a.i_flush = flush;
    assign if_b.i_valid = valid;  assign if_b.i_instruction = inst[31:7];  assign if_b.i_imm_sel = sel;
    assign if_b.i_thread_index = thr;  assign if_b.i_stall = stall;  assign if_b.i_flush = flush;
    assign if_c.i_valid = valid;  assign if_c.i_instruction = inst[31:7];  assign if_c.i_imm_sel = sel;
    assign if_c.i_thread_index = thr;  assign if_c.i_stall = stall;  assign if_c.i_flush = flush;

    immgen_pipe #(.XLEN(32), .NUM_THREADS(16), .HART_ID_BASE(BASE_A), .PIPE_STAGES(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    immgen_pipe #(.XLEN(64), .NUM_THREADS(16), .HART_ID_BASE(BASE_B), .PIPE_STAGES(2))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    immgen_pipe #(.XLEN(32), .NUM_THREADS(16), .HART_ID_BASE(BASE_C), .PIPE_STAGES(3))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    function automatic int pipe_of(input int k);
        return k + 1;
    endfunction

    function automatic logic [63:0] base_of(input int k);
        if (k == 0) return {32'b0, BASE_A};
        if (k == 1) return BASE_B;
        return {32'b0, BASE_C};
    endfunction

    // Reference immediate; k==1 is the 64-bit instance.
    function automatic logic [63:0] calc(input int k, input logic [31:0] in,
                                         input logic [2:0] s, input logic [TW-1:0] t);
        logic [63:0] r;
        r = '0;
        case (s)
            3'd0: r = {{32{in[31]}}, in[31:12], 12'h000};
            3'd1: r = {{52{in[31]}}, in[31:20]};
            3'd2: r = {{52{in[31]}}, in[31:25], in[11:7]};
            3'd3: r = {{51{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
            3'd4: r = {{43{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
            3'd5: r = base_of(k) + 64'(t);
`ifdef IMMGEN_ZIMM_EN
            3'd6: r = 64'(in[19:15]);
            3'd7: r = (k == 1) ? 64'(in[25:20]) : 64'(in[24:20]);
`endif
            default: r = '0;
        endcase
        if (k != 1) r[63:32] = '0;
        return r;
    endfunction

    task automatic model_edge();
        ent_t nq[$];
        ent_t e;
        if (flush) begin
            exp_q.delete();
        end else if (!stall) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].pos != pipe_of(exp_q[i].k)) begin
                    e = exp_q[i];
                    e.pos++;
                    nq.push_back(e);
                end
            end
            if (valid) begin
                for (int k = 0; k < 3; k++) begin
                    e.k = k; e.d = calc(k, inst, sel, thr); e.t = thr; e.pos = 1;
                    nq.push_back(e);
                end
            end
            exp_q = nq;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic          gv;
        logic          ev;
        logic [63:0]   gd;
        logic [TW-1:0] gt;
        int            idx;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin gv = if_a.o_valid; gd = 64'(if_a.o_imm_out); gt = if_a.o_thread_index; end
                1:       begin gv = if_b.o_valid; gd = if_b.o_imm_out;      gt = if_b.o_thread_index; end
                default: begin gv = if_c.o_valid; gd = 64'(if_c.o_imm_out); gt = if_c.o_thread_index; end
            endcase
            idx = -1;
            foreach (exp_q[i]) if (idx < 0 && exp_q[i].k == k) idx = i;
            ev = 1'b0;
            if (idx >= 0) ev = (exp_q[idx].pos == pipe_of(k));
            tests++;
            assert (gv === ev) else begin
                fails++;
                $error("FAIL %s dut%0d valid: got %0b expected %0b", tag, k, gv, ev);
            end
            if (ev) begin
                tests++;
                assert (gd === exp_q[idx].d) else begin
                    fails++;
                    $error("FAIL %s dut%0d imm: got %h expected %h", tag, k, gd, exp_q[idx].d);
                end
                tests++;
                assert (gt === exp_q[idx].t) else begin
                    fails++;
                    $error("FAIL %s dut%0d thread: got %0d expected %0d", tag, k, gt, exp_q[idx].t);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_valid"}, 64'(if_a.o_valid), 64'd0);
        chk({tag, "_a_imm"},   64'(if_a.o_imm_out), 64'd0);
        chk({tag, "_a_thr"},   64'(if_a.o_thread_index), 64'd0);
        chk({tag, "_b_valid"}, 64'(if_b.o_valid), 64'd0);
        chk({tag, "_b_imm"},   if_b.o_imm_out, 64'd0);
        chk({tag, "_c_valid"}, 64'(if_c.o_valid), 64'd0);
        chk({tag, "_c_imm"},   64'(if_c.o_imm_out), 64'd0);
        chk({tag, "_c_thr"},   64'(if_c.o_thread_index), 64'd0);
    endtask

    task automatic step(input logic v, input logic [31:0] in, input logic [2:0] s,
                        input logic [TW-1:0] t, input logic st, input logic fl, input string tag);
        @(negedge clk);
        valid = v; inst = in; sel = s; thr = t; stall = st; flush = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed immediates of every type.
        step(1'b1, 32'hFFF0_0093, 3'd1, 4'd0, 1'b0, 1'b0, "i_type");
        chk("i_type_a", 64'(if_a.o_imm_out), 64'h0000_0000_FFFF_FFFF);
        step(1'b1, 32'h8000_0037, 3'd0, 4'd1, 1'b0, 1'b0, "u_type");
        step(1'b1, 32'hFE00_0EE3, 3'd3, 4'd2, 1'b0, 1'b0, "b_type");
        chk("u_type_b64", if_b.o_imm_out, 64'hFFFF_FFFF_8000_0000);
        step(1'b1, 32'hFF5F_F0EF, 3'd4, 4'd7, 1'b0, 1'b0, "j_type");
        chk("b_type_b64", if_b.o_imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, 32'hFE11_2E23, 3'd2, 4'd9, 1'b0, 1'b0, "s_type");
        step(1'b1, 32'h0000_0000, 3'd5, 4'd3, 1'b0, 1'b0, "hartid");
        chk("hartid_wrap_a", 64'(if_a.o_imm_out), 64'd1);
        chk("hartid_thr_a", 64'(if_a.o_thread_index), 64'd3);
        step(1'b1, 32'h3008_D0F3, 3'd6, 4'd4, 1'b0, 1'b0, "zimm");
        chk("zimm_a", 64'(if_a.o_imm_out), ZIMM_EXP);
        step(1'b1, 32'h43F0_D093, 3'd7, 4'd5, 1'b0, 1'b0, "shamt");
        for (int n = 0; n < 3; n++) step(1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0, "drain1");

        // Stream of four with a two-cycle stall; the third word is held by the producer.
        step(1'b1, 32'h0010_0093, 3'd1, 4'd1, 1'b0, 1'b0, "stall_s0");
        step(1'b1, 32'h8000_1037, 3'd0, 4'd2, 1'b0, 1'b0, "stall_s1");
        step(1'b1, 32'hFFF0_0113, 3'd1, 4'd3, 1'b1, 1'b0, "stall_h0");
        step(1'b1, 32'hFFF0_0113, 3'd1, 4'd3, 1'b1, 1'b0, "stall_h1");
        step(1'b1, 32'hFFF0_0113, 3'd1, 4'd3, 1'b0, 1'b0, "stall_s2");
        step(1'b1, 32'h0000_0000, 3'd5, 4'd15, 1'b0, 1'b0, "stall_s3");
        for (int n = 0; n < 4; n++) step(1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0, "drain2");

        // Flush together with stall drops everything in flight and the new word.
        step(1'b1, 32'h7FF0_0093, 3'd1, 4'd6, 1'b0, 1'b0, "flush_f0");
        step(1'b1, 32'h8000_006F, 3'd4, 4'd7, 1'b0, 1'b0, "flush_f1");
        step(1'b1, 32'h1230_0093, 3'd1, 4'd8, 1'b1, 1'b1, "flush_kill");
        step(1'b1, 32'hABCD_E037, 3'd0, 4'd9, 1'b0, 1'b0, "flush_next");
        for (int n = 0; n < 3; n++) step(1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0, "drain3");

        // Random stream including occasional stall and flush.
        for (int n = 0; n < 24; n++) begin
            step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                 TW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), "rand");
        end

        // Asynchronous reset with entries in flight, checked between clock edges.
        step(1'b1, 32'hFFF0_0093, 3'd1, 4'd10, 1'b0, 1'b0, "areset_p");
        step(1'b1, 32'h8000_0037, 3'd0, 4'd11, 1'b0, 1'b0, "areset_q");
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) step(1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
